spi_deserializer: RTL and testbench

Receive-side companion to the team's SPI serializer. Monitors an active-low chip select, an idle-low serial clock and a data line, and shifts in one DATA_SIZE-bit word per frame, least-significant bit first. Presents each completed word on a parallel output with a valid/acknowledge handshake. Sits directly downstream of the serializer, either for loopback test or on a slave-side FPGA, and runs on its own system clock, asynchronous to the serial clock.

---
 rtl/spi_deserializer.sv | 176 +++++++++++++++++
 tb/tb_spi_deserializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_deserializer.sv
// spi_deserializer
// Receives one DATA_SIZE-bit word per active-low chip-select frame, LSB first,
// sampling the data line on serial-clock rising edges. Completed words are
// offered on o_Data with a valid/acknowledge handshake. Frames of the wrong
// length raise a one-cycle o_Frame_Error pulse. Good words that arrive while the
// previous word is unacknowledged are dropped and raise a one-cycle o_Overrun pulse.
//
// Build option: define DESER_SYNC_EN to put a two-flop synchroniser on every
// serial input. Define it for sources that are asynchronous to i_Clock. When
// DESER_SYNC_EN is left undefined, each input passes through a single register.
// That is only safe when the serial source is clocked from i_Clock.

module spi_deserializer #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_CS,
    input  logic                 i_SCLK,
    input  logic                 i_MOSI,
    input  logic                 i_Ack,
    output logic [DATA_SIZE-1:0] o_Data,
    output logic                 o_Valid,
    output logic                 o_Frame_Error,
    output logic                 o_Overrun
);

    // The counter must reach DATA_SIZE+1 so that long frames saturate there
    // instead of wrapping back onto DATA_SIZE.
    localparam int CNT_W = $clog2(DATA_SIZE) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_SIZE);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_SIZE + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_next;

    logic cs_cur, sclk_cur, mosi_cur;
    logic cs_prev, sclk_prev;

    logic [DATA_SIZE-1:0] shift_reg;
    logic [CNT_W-1:0]     bit_cnt;

    logic cs_fall, cs_rise, sclk_rise;
    logic clear_frame, shift_en, frame_end;
    logic word_load, word_drop, frame_bad;

`ifdef DESER_SYNC_EN
    logic cs_meta, sclk_meta, mosi_meta;

    // Two-flop synchroniser on each serial input. The data line goes through the
    // same stages so that it stays aligned with the serial clock.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cs_meta   <= 1'b0;
            sclk_meta <= 1'b0;
            mosi_meta <= 1'b0;
            cs_cur    <= 1'b0;
            sclk_cur  <= 1'b0;
            mosi_cur  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the two stages shift together.
            // With blocking assignments the stages would collapse into one.
            cs_meta   <= i_CS;
            sclk_meta <= i_SCLK;
            mosi_meta <= i_MOSI;
            cs_cur    <= cs_meta;
            sclk_cur  <= sclk_meta;
            mosi_cur  <= mosi_meta;
        end
    end
`else
    // Single capture register per serial input. The source must be on i_Clock.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cs_cur   <= 1'b0;
            sclk_cur <= 1'b0;
            mosi_cur <= 1'b0;
        end else begin
            cs_cur   <= i_CS;
            sclk_cur <= i_SCLK;
            mosi_cur <= i_MOSI;
        end
    end
`endif

    // Previous-sample registers used for edge detection. CS resets to 0, so a
    // chip select that is held low through reset never appears as a falling edge.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cs_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            cs_prev   <= cs_cur;
            sclk_prev <= sclk_cur;
        end
    end

    assign cs_fall   =  cs_prev && !cs_cur;
    assign cs_rise   = !cs_prev &&  cs_cur;
    assign sclk_rise = !sclk_prev && sclk_cur;

    // State register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic: a frame opens on a CS falling edge and closes on a CS rising edge
    always_comb begin
        // NOTE: assigning a default first keeps this logic combinational on every path.
        // Without the default, a synthesis tool would infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and event decode for the current state
    always_comb begin
        clear_frame = 1'b0;
        shift_en    = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: clear_frame = cs_fall;
            SHIFT: begin
                shift_en  = sclk_rise && !cs_cur;
                frame_end = cs_rise;
            end
            default: ;
        endcase
    end

    assign word_load = frame_end && (bit_cnt == CNT_FULL) && (!o_Valid || i_Ack);
    assign word_drop = frame_end && (bit_cnt == CNT_FULL) &&   o_Valid && !i_Ack;
    assign frame_bad = frame_end && (bit_cnt != CNT_FULL);

    // Shift register and saturating bit counter. Bits arrive LSB first and enter at the top.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clear_frame) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (shift_en) begin
            shift_reg <= {mosi_cur, shift_reg[DATA_SIZE-1:1]};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Word output, valid/ack handshake and one-cycle status pulses
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Data        <= '0;
            o_Valid       <= 1'b0;
            o_Frame_Error <= 1'b0;
            o_Overrun     <= 1'b0;
        end else begin
            o_Frame_Error <= frame_bad;
            o_Overrun     <= word_drop;
            if (word_load) begin
                o_Data  <= shift_reg;
                o_Valid <= 1'b1;
            end else if (o_Valid && i_Ack) begin
                o_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_deserializer.sv
// Self-checking bench for spi_deserializer (DATA_SIZE = 32).
// Each frame that should deliver a word pushes that word onto a queue. The word
// is popped and compared on the edge where the output is expected to change.
// Set SYNC_EN to 1 when the RTL is built with DESER_SYNC_EN defined.

module tb_spi_deserializer;

    parameter bit SYNC_EN = 1'b0;

    localparam int DW      = 32;
    localparam int UPD     = SYNC_EN ? 2 : 1;   // edges after the sampling edge
    localparam int HALF    = 4;                 // SCLK half-period in clocks
    localparam int LB_HALF = SYNC_EN ? 3 : 2;   // loopback serializer half-period

    typedef enum int { K_LOAD, K_OVR, K_FERR } end_kind_t;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          cs   = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          ack  = 1'b0;
    logic [DW-1:0] data;
    logic          valid;
    logic          ferr;
    logic          ovr;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] cur_data = '0;

    spi_deserializer #(.DATA_SIZE(DW)) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_CS          (cs),
        .i_SCLK        (sclk),
        .i_MOSI        (mosi),
        .i_Ack         (ack),
        .o_Data        (data),
        .o_Valid       (valid),
        .o_Frame_Error (ferr),
        .o_Overrun     (ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_low(input int half);
        tick(half);                 // minimum CS-high time
        cs = 1'b0;
        tick(half);
    endtask

    task automatic send_bit(input logic b, input int half);
        sclk = 1'b0;
        mosi = b;
        tick(half);
        sclk = 1'b1;
        tick(half);
    endtask

    task automatic cs_high(input int half);
        sclk = 1'b0;
        tick(half);
        cs = 1'b1;
    endtask

    task automatic send_frame(input logic [DW-1:0] word, input int nbits, input int half);
        cs_low(half);
        for (int i = 0; i < nbits; i++) send_bit(word[i % DW], half);
        cs_high(half);
    endtask

    // Called right after CS rises. Checks the cycle before the update edge, the
    // update edge itself, and the cycle after it.
    task automatic check_end(input end_kind_t kind, input logic exp_valid);
        repeat (UPD) @(posedge clk);
        @(negedge clk);
        check("early_ferr", ferr, 0);
        check("early_ovr",  ovr,  0);
        @(negedge clk);
        case (kind)
            K_LOAD: begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    cur_data = exp_q.pop_front();
                    check("load_data",  data,  cur_data);
                    check("load_valid", valid, 1);
                    check("load_ferr",  ferr,  0);
                    check("load_ovr",   ovr,   0);
                end
            end
            K_OVR: begin
                check("ovr_pulse", ovr,   1);
                check("ovr_data",  data,  cur_data);
                check("ovr_valid", valid, 1);
                check("ovr_ferr",  ferr,  0);
            end
            default: begin
                check("ferr_pulse", ferr,  1);
                check("ferr_ovr",   ovr,   0);
                check("ferr_valid", valid, exp_valid);
                check("ferr_data",  data,  cur_data);
            end
        endcase
        @(negedge clk);
        check("pulse_end_ferr", ferr, 0);
        check("pulse_end_ovr",  ovr,  0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        check("pre_ack_valid", valid, 1);
        @(posedge clk);
        #1;
        ack = 1'b0;
        @(negedge clk);
        check("post_ack_valid", valid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        cur_data = '0;
        @(negedge clk);
        check("rst_data",  data,  0);
        check("rst_valid", valid, 0);
        check("rst_ferr",  ferr,  0);
        check("rst_ovr",   ovr,   0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] w;

        // Reset state
        tick(1);
        do_reset();

        // Full word, held until acknowledged
        exp_q.push_back(32'hA5C31E77);
        send_frame(32'hA5C31E77, 32, HALF);
        check_end(K_LOAD, 1'b1);
        tick(10);
        check("hold_valid", valid, 1);
        check("hold_data",  data,  32'hA5C31E77);
        do_ack();

        // Short frame after a fresh reset, then a good frame
        do_reset();
        send_frame(32'h12345678, 31, HALF);
        check_end(K_FERR, 1'b0);
        exp_q.push_back(32'h0000FFFF);
        send_frame(32'h0000FFFF, 32, HALF);
        check_end(K_LOAD, 1'b1);
        do_ack();

        // Zero-bit frame and over-long frame (counter must saturate, not wrap)
        cs_low(HALF);
        cs_high(HALF);
        check_end(K_FERR, 1'b0);
        send_frame(32'h0F0F0F0F, 96, HALF);
        check_end(K_FERR, 1'b0);

        // Overrun: a second good word arrives without an acknowledge
        exp_q.push_back(32'h11111111);
        send_frame(32'h11111111, 32, HALF);
        check_end(K_LOAD, 1'b1);
        send_frame(32'h22222222, 32, HALF);
        check_end(K_OVR, 1'b1);

        // Acknowledge lands exactly on the completion edge of the next word
        exp_q.push_back(32'h33333333);
        send_frame(32'h33333333, 32, HALF);
        repeat (UPD) @(posedge clk);
        #1;
        ack = 1'b1;
        @(negedge clk);
        check("ack_edge_pre_valid", valid, 1);
        check("ack_edge_pre_data",  data,  32'h11111111);
        @(posedge clk);
        #1;
        ack = 1'b0;
        @(negedge clk);
        cur_data = exp_q.pop_front();
        check("ack_edge_data",  data,  cur_data);
        check("ack_edge_valid", valid, 1);
        check("ack_edge_ovr",   ovr,   0);
        @(negedge clk);
        check("ack_edge_hold_valid", valid, 1);
        @(posedge clk);
        #1;
        do_ack();

        // Reset in the middle of a frame while CS stays low
        cs_low(HALF);
        for (int i = 0; i < 10; i++) send_bit(1'b1, HALF);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        cur_data = '0;
        for (int i = 10; i < 32; i++) send_bit(1'b0, HALF);
        cs_high(HALF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_mid_valid", valid, 0);
            check("rst_mid_ferr",  ferr,  0);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(32'hDEADBEEF);
        send_frame(32'hDEADBEEF, 32, HALF);
        check_end(K_LOAD, 1'b1);
        do_ack();

        // Loopback-style source clocked from i_Clock, random words
        for (int k = 0; k < 8; k++) begin
            w = $urandom;
            exp_q.push_back(w);
            send_frame(w, 32, LB_HALF);
            check_end(K_LOAD, 1'b1);
            do_ack();
        end

        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
